// File: rtl/demod_frame_sync_ctrl.sv
// Frame-sync controller: hunts for a sync word, confirms it over consecutive
// frame periods, then flywheels on frame timing. In lock it forwards payload
// words through a one-deep output register with SOF/EOF markers.
module demod_frame_sync_ctrl #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] SYNC_WORD = 16'hFFFF,
  parameter int                FRAME_LEN = 8,
  parameter int                CONFIRM   = 2,
  parameter int                MISS_MAX  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic              locked,
  output logic [7:0]        frame_cnt,
  output logic              sync_err
);

  localparam logic [7:0] LAST_POS  = 8'(FRAME_LEN);
  localparam logic [3:0] CONFIRM_N = 4'(CONFIRM);
  localparam logic [3:0] MISS_N    = 4'(MISS_MAX);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t     state_reg;
  logic [7:0] pos_reg;
  logic [3:0] hits_reg;
  logic [3:0] miss_reg;

  logic       accept;
  logic       match;
  logic       sync_slot;
  logic [7:0] pos_next;
  logic [3:0] hits_inc;
  logic [3:0] miss_inc;

  // Output register is one deep: accept whenever it is empty or draining.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign match     = (in_data == SYNC_WORD);
  assign sync_slot = (pos_reg == 8'd0);
  assign pos_next  = (pos_reg == LAST_POS) ? 8'd0 : pos_reg + 8'd1;
  assign hits_inc  = hits_reg + 4'd1;
  assign miss_inc  = miss_reg + 4'd1;
  assign locked    = (state_reg == LOCKED);

  // Sync FSM, slot counter and output register in one sequential block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SEARCH;
      pos_reg   <= 8'd0;
      hits_reg  <= 4'd0;
      miss_reg  <= 4'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_cnt <= 8'd0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      // Drain first; a load below in the same cycle overrides it.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        case (state_reg)
          SEARCH: begin
            // Non-matching words are simply dropped while hunting.
            if (match) begin
              hits_reg  <= 4'd1;
              pos_reg   <= 8'd1;
              state_reg <= (CONFIRM_N == 4'd1) ? LOCKED : VERIFY;
            end
          end
          VERIFY: begin
            if (sync_slot) begin
              if (match) begin
                hits_reg <= hits_inc;
                pos_reg  <= 8'd1;
                if (hits_inc == CONFIRM_N) begin
                  state_reg <= LOCKED;
                end
              end else begin
                // The failing word is consumed, not re-tried as a candidate.
                hits_reg  <= 4'd0;
                state_reg <= SEARCH;
              end
            end else begin
              pos_reg <= pos_next;
            end
          end
          LOCKED: begin
            if (sync_slot) begin
              if (match) begin
                miss_reg <= 4'd0;
                pos_reg  <= 8'd1;
              end else if (miss_inc == MISS_N) begin
                miss_reg  <= 4'd0;
                hits_reg  <= 4'd0;
                pos_reg   <= 8'd0;
                sync_err  <= 1'b1;
                state_reg <= SEARCH;
              end else begin
                // Flywheel: keep frame timing through a missed sync word.
                miss_reg <= miss_inc;
                pos_reg  <= 8'd1;
              end
            end else begin
              out_data  <= in_data;
              out_valid <= 1'b1;
              out_sof   <= (pos_reg == 8'd1);
              out_eof   <= (pos_reg == LAST_POS);
              if (pos_reg == LAST_POS) begin
                frame_cnt <= frame_cnt + 8'd1;
              end
              pos_reg <= pos_next;
            end
          end
          default: state_reg <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demod_frame_sync_ctrl.sv
// Scoreboard bench for demod_frame_sync_ctrl: a frame-level reference model
// predicts forwarded words; a separate monitor pops and compares them.
module tb_demod_frame_sync_ctrl;

  localparam int          FL   = 8;
  localparam int          CONF = 2;
  localparam int          MMAX = 2;
  localparam logic [15:0] SW   = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eof;
  logic        locked;
  logic [7:0]  frame_cnt;
  logic        sync_err;

  demod_frame_sync_ctrl #(
    .DATA_W(16), .SYNC_WORD(SW), .FRAME_LEN(FL), .CONFIRM(CONF), .MISS_MAX(MMAX)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
    .locked(locked), .frame_cnt(frame_cnt), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        sof;
    logic        eof;
    logic [7:0]  fc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   gap_pct  = 0;

  // Reference model, in frame terms: mode 0 hunting, 1 confirming, 2 locked.
  int   m_mode, m_pos, m_hits, m_miss;
  logic [7:0] m_fcnt;
  bit   m_occ, m_err;

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_hits = 0; m_miss = 0;
    m_fcnt = 8'd0; m_occ = 1'b0; m_err = 1'b0;
    q.delete();
  endfunction

  function automatic void model_word(input logic [15:0] d);
    exp_t e;
    if (m_mode == 0) begin
      if (d == SW) begin
        m_hits = 1; m_pos = 1;
        m_mode = (CONF == 1) ? 2 : 1;
      end
    end else if (m_pos == 0) begin
      if (m_mode == 1) begin
        if (d == SW) begin
          m_hits++; m_pos = 1;
          if (m_hits == CONF) m_mode = 2;
        end else begin
          m_mode = 0; m_hits = 0;
        end
      end else begin
        if (d == SW) begin
          m_miss = 0; m_pos = 1;
        end else begin
          m_miss++;
          if (m_miss == MMAX) begin
            m_mode = 0; m_miss = 0; m_hits = 0; m_err = 1'b1;
          end else begin
            m_pos = 1;
          end
        end
      end
    end else begin
      if (m_mode == 2) begin
        if (m_pos == FL) m_fcnt = m_fcnt + 8'd1;
        e.d = d; e.sof = (m_pos == 1); e.eof = (m_pos == FL); e.fc = m_fcnt;
        q.push_back(e);
        m_occ = 1'b1;
      end
      m_pos = (m_pos == FL) ? 0 : m_pos + 1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit v, input logic [15:0] d, input bit r, output bit acc);
    in_valid = v; in_data = d; out_ready = r;
    #1;
    chk("in_ready", int'(in_ready), int'(!m_occ || r));
    chk("locked", int'(locked), int'(m_mode == 2));
    chk("sync_err", int'(sync_err), int'(m_err));
    chk("out_valid", int'(out_valid), int'(m_occ));
    chk("frame_cnt", int'(frame_cnt), int'(m_fcnt));
    if (m_occ && q.size() > 0) chk("out_data_hold", int'(out_data), int'(q[0].d));
    acc = v && in_ready;
    $display("cyc t=%0t v=%0b d=%h rdy=%0b acc=%0b locked=%0b ov=%0b od=%h",
             $time, v, d, r, acc, locked, out_valid, out_data);
    m_err = 1'b0;
    if (r && m_occ) m_occ = 1'b0;
    if (acc) model_word(d);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d, input int rdy_pct);
    bit acc;
    int n;
    n = 0;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
      step(1'b0, 16'($urandom), ($urandom_range(0, 99) < rdy_pct), acc);
    do begin
      step(1'b1, d, ($urandom_range(0, 99) < rdy_pct), acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [15:0] s, input logic [15:0] base, input int rdy_pct);
    send(s, rdy_pct);
    for (int i = 0; i < FL; i++) send(base + 16'(i), rdy_pct);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    bit acc;
    repeat (4) step(1'b0, 16'h0, 1'b1, acc);
    chk("queue_empty", q.size(), 0);
  endtask

  // Monitor: compares each word at the cycle the DUT hands it downstream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", int'(out_data), -1);
        end else begin
          e = q.pop_front();
          chk("out_data", int'(out_data), int'(e.d));
          chk("out_sof", int'(out_sof), int'(e.sof));
          chk("out_eof", int'(out_eof), int'(e.eof));
          chk("frame_cnt_eof", int'(frame_cnt), int'(e.fc));
        end
      end
    end
  end

  initial begin
    bit acc;
    in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1; rst = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset(2);

    // Lock acquire.
    send_frame(SW, 16'h0001 - 16'h0000, 100);
    send_frame(SW, 16'h0010, 100);
    chk("acq_frame_cnt", int'(m_fcnt), 1);
    drain();

    // False sync then a clean two-frame lock.
    do_reset(1);
    send_frame(SW, 16'h0100, 100);
    send(16'h1234, 100);
    send_frame(SW, 16'h0200, 100);
    send_frame(SW, 16'h0300, 100);
    drain();

    // Flywheel on one miss, then loss on two consecutive misses.
    send_frame(16'hAAAA, 16'h0400, 100);
    send_frame(SW, 16'h0500, 100);
    send_frame(16'hAAAA, 16'h0600, 100);
    send_frame(16'hAAAA, 16'h0700, 100);
    send_frame(SW, 16'h0800, 100);
    drain();

    // Backpressure mid-frame.
    send_frame(SW, 16'h0900, 100);
    send_frame(SW, 16'h0A00, 100);
    send(SW, 100);
    send(16'h0B00, 100);
    send(16'h0B01, 100);
    repeat (5) step(1'b1, 16'h0B02, 1'b0, acc);
    for (int i = 2; i < FL; i++) send(16'h0B00 + 16'(i), 100);
    drain();

    // Gapped input with random backpressure.
    gap_pct = 50;
    repeat (3) send_frame(SW, 16'($urandom), 60);
    drain();

    // Randomized frames: occasional bad sync words and junk insertions.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) send(16'($urandom), 70);
      send_frame(($urandom_range(0, 4) == 0) ? 16'($urandom) : SW, 16'($urandom), 70);
    end
    gap_pct = 0;
    drain();

    // Reset mid-frame while a word sits in the output register.
    send_frame(SW, 16'h0C00, 100);
    send(SW, 100);
    send(16'h0D00, 0);
    step(1'b0, 16'h0, 1'b0, acc);
    chk("pre_rst_out_valid", int'(out_valid), 1);
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    @(negedge clk);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
